bt_syncword_correlator: RTL and testbench
=========================================

Name: bt_syncword_correlator

Overview:
Receive-side access-code detector, the receive counterpart of the TX access-code serializer. It samples the 1 Mb/s received bit stream (rxbit) on a bit strobe and slides a 64-bit correlation window over it. Each new bit is compared against the programmed sync word. When the agreement count reaches the programmed threshold inside an armed search window, it fires a one-shot sync pulse. This pulse feeds packet-header framing and the slave/master slot-timing capture.

Parameters:
SW_W, 64, sync word width in bits
CORR_W, 7, correlation count width (holds 0..64)
WIN_W, 16, search window counter width (bits)

Ports:
clk_6M  in  1  system clock, 6 MHz
rstz  in  1  synchronous reset, active low
bit_en  in  1  1-cycle strobe, one per received bit (every 6 clk_6M)
rxbit  in  1  received bit, valid when bit_en=1
regi_syncword  in  64  expected sync word; bit [0] is received first
regi_correthreshold  in  6  minimum agreeing bits for detection
search_start_p  in  1  arm or re-arm the search
search_cancel_p  in  1  abort the search
regi_search_window  in  WIN_W  bits allowed after fill; 0 = unlimited
sync_detect_p  out  1  one-cycle pulse on detection
corr_value  out  CORR_W  registered agreement count of the latest bit
corr_peak  out  CORR_W  corr_value captured at detection
searching  out  1  high while in FILL or SEARCH
timeout_p  out  1  one-cycle pulse when the window expires with no detection

Behaviour:
- One clock domain (clk_6M). Reset is synchronous, active low (rstz=0 sampled on a clk_6M edge).
- Reset values: all outputs 0; shift register 0; counters 0; FSM in IDLE.
- Shift register: on bit_en, sreg <= {rxbit, sreg[63:1]}. After 64 bits, sreg[0] holds the earliest bit and aligns with regi_syncword[0].
- The register shifts on every bit_en regardless of FSM state.
- Correlation: agree = popcount(~(sreg ^ regi_syncword)), range 0..64.
  - corr_value <= agree on the clock edge after each shift.
  - Total latency: the bit_en sample edge, then corr_value updated 1 edge later, then the sync_detect_p cycle.
- Threshold compare is unsigned: agree >= {1'b0, regi_correthreshold}.
- FSM states:
  - IDLE: searching=0. search_start_p -> FILL; clear fill_cnt and win_cnt.
  - FILL: searching=1. fill_cnt increments per bit_en. When the 64th bit since start is shifted in -> SEARCH.
    - Detection is evaluated on that 64th bit. This allows a sync word that arrives immediately after arming.
  - SEARCH: searching=1. On each post-shift evaluation:
    - If agree >= threshold: sync_detect_p=1 for 1 cycle, corr_peak <= agree, -> LOCKED.
    - Else win_cnt increments. When regi_search_window != 0 and win_cnt reaches regi_search_window: timeout_p=1 for 1 cycle, -> IDLE.
  - LOCKED: searching=0, no further detections. search_start_p -> FILL (re-arm). search_cancel_p -> IDLE.
- Priorities and simultaneous events:
  - search_cancel_p beats search_start_p in the same cycle (-> IDLE, no pulses).
  - search_start_p during FILL or SEARCH restarts FILL and clears counters. An evaluation pending in that cycle is discarded.
  - Detection beats timeout on the same bit: only sync_detect_p fires.
  - sync_detect_p and timeout_p are never high together, and each is high for exactly one clk_6M cycle.
- win_cnt saturates at its maximum when the window is unlimited (regi_search_window=0); no wrap.
- regi_correthreshold=0 is legal: detection occurs on the first evaluation after fill.
- rstz low mid-search: next edge returns to IDLE, outputs cleared, no pulse emitted.
- regi_* inputs are quasi-static during a search. Changing them mid-search takes effect on the next evaluation.

Test Plan:
1. Arm, regi_syncword=64'h475c58cc73345e72, threshold 60, window 0; send that word LSB first, bit_en every 6 clocks -> sync_detect_p 2 edges after the 64th bit_en; corr_value=corr_peak=64; searching falls.
2. Same word with 4 bits flipped -> detect with corr_peak=60. With 5 bits flipped -> no detect, corr_value=59, searching stays 1.
3. Window 10, random bits never reaching threshold -> timeout_p exactly once, on the 74th bit after arm; FSM IDLE; no sync_detect_p.
4. 30 random bits, then the sync word, window 0 -> detection on the last sync bit only. No earlier pulse during FILL even though sreg holds reset zeros.
5. search_start_p and search_cancel_p in the same cycle during SEARCH -> IDLE, searching=0. Then search_start_p in LOCKED -> FILL, fill_cnt restarts, re-detection after a further 64 bits.
6. rstz=0 for 1 cycle while 50 bits into FILL -> all outputs 0 next edge. A subsequent full sync word without re-arming -> no sync_detect_p.

Source files
------------

// File: rtl/bt_syncword_correlator.sv
// Receive access-code correlator: slides a 64-bit window over the received
// bit stream and fires a one-shot sync pulse once agreement with the
// programmed sync word reaches the threshold inside an armed search window.
module bt_syncword_correlator #(
  parameter int SW_W   = 64,
  parameter int CORR_W = 7,
  parameter int WIN_W  = 16
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              bit_en,
  input  logic              rxbit,
  input  logic [SW_W-1:0]   regi_syncword,
  input  logic [5:0]        regi_correthreshold,
  input  logic              search_start_p,
  input  logic              search_cancel_p,
  input  logic [WIN_W-1:0]  regi_search_window,
  output logic              sync_detect_p,
  output logic [CORR_W-1:0] corr_value,
  output logic [CORR_W-1:0] corr_peak,
  output logic              searching,
  output logic              timeout_p
);

  localparam int unsigned FILL_W = $clog2(SW_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SW_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, SEARCH, LOCKED} state_t;

  state_t             state, state_nx;
  logic [SW_W-1:0]    sreg;
  logic               shift_d;
  logic               ev1, ev2;
  logic [FILL_W-1:0]  fill_cnt, fill_nx;
  logic [WIN_W-1:0]   win_cnt, win_nx, win_inc;
  logic [CORR_W-1:0]  agree;
  logic [CORR_W-1:0]  thr_ext;
  logic               hit, ctl, decide, expire;
  logic               det_nx, to_nx;

  assign thr_ext = CORR_W'(regi_correthreshold);
  assign hit     = (corr_value >= thr_ext);
  assign ctl     = search_start_p | search_cancel_p;
  assign win_inc = (win_cnt == '1) ? win_cnt : win_cnt + 1'b1;
  assign expire  = (regi_search_window != '0) && (win_inc >= regi_search_window);
  // An evaluation is acted on at the end of fill (64th bit) or in SEARCH,
  // unless a start/cancel in the same cycle overrides it.
  assign decide  = ev2 && !ctl &&
                   (((state == FILL) && (fill_cnt == FILL_LAST)) || (state == SEARCH));

  // Agreement count between the window and the sync word
  always_comb begin
    agree = '0;
    for (int unsigned i = 0; i < SW_W; i++)
      agree = agree + CORR_W'(~(sreg[i] ^ regi_syncword[i]));
  end

  // Bit shift register and the shift -> correlate -> evaluate pipeline.
  // A start clears the evaluation tags so bits shifted before arming are
  // never counted as fill bits.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      sreg       <= '0;
      shift_d    <= 1'b0;
      ev1        <= 1'b0;
      ev2        <= 1'b0;
      corr_value <= '0;
    end else begin
      if (bit_en) sreg <= {rxbit, sreg[SW_W-1:1]};
      shift_d <= bit_en;
      ev1     <= bit_en & ~search_start_p;
      ev2     <= ev1 & ~search_start_p;
      if (shift_d) corr_value <= agree;
    end
  end

  // State, counters, peak capture and registered pulses
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      win_cnt       <= '0;
      corr_peak     <= '0;
      sync_detect_p <= 1'b0;
      timeout_p     <= 1'b0;
    end else begin
      state         <= state_nx;
      fill_cnt      <= fill_nx;
      win_cnt       <= win_nx;
      sync_detect_p <= det_nx;
      timeout_p     <= to_nx;
      if (det_nx) corr_peak <= corr_value;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    win_nx   = win_cnt;
    if (search_cancel_p) begin
      state_nx = IDLE;
    end else if (search_start_p) begin
      state_nx = FILL;
      fill_nx  = '0;
      win_nx   = '0;
    end else begin
      case (state)
        FILL: begin
          if (ev2) begin
            if (fill_cnt == FILL_LAST) state_nx = hit ? LOCKED : SEARCH;
            else                       fill_nx  = fill_cnt + 1'b1;
          end
        end
        SEARCH: begin
          if (ev2) begin
            if (hit) begin
              state_nx = LOCKED;
            end else begin
              win_nx = win_inc;
              if (expire) state_nx = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status and pulse decode; detection wins over timeout on the same bit
  always_comb begin
    searching = (state == FILL) || (state == SEARCH);
    det_nx    = decide && hit;
    to_nx     = decide && !hit && (state == SEARCH) && expire;
  end

endmodule

// File: tb/tb_bt_syncword_correlator.sv
// Self-checking bench for bt_syncword_correlator with a behavioural model
// and an expected-result queue per received bit.
module tb_bt_syncword_correlator;

  localparam logic [63:0] SW = 64'h475c58cc73345e72;

  logic        clk_6M = 1'b0;
  logic        rstz, bit_en, rxbit;
  logic [63:0] regi_syncword;
  logic [5:0]  regi_correthreshold;
  logic        search_start_p, search_cancel_p;
  logic [15:0] regi_search_window;
  logic        sync_detect_p, searching, timeout_p;
  logic [6:0]  corr_value, corr_peak;

  always #5 clk_6M = ~clk_6M;

  bt_syncword_correlator #(.SW_W(64), .CORR_W(7), .WIN_W(16)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .bit_en(bit_en), .rxbit(rxbit),
    .regi_syncword(regi_syncword), .regi_correthreshold(regi_correthreshold),
    .search_start_p(search_start_p), .search_cancel_p(search_cancel_p),
    .regi_search_window(regi_search_window),
    .sync_detect_p(sync_detect_p), .corr_value(corr_value), .corr_peak(corr_peak),
    .searching(searching), .timeout_p(timeout_p)
  );

  typedef struct {
    logic [6:0] corr;
    logic       det;
    logic       to;
  } exp_t;
  exp_t q[$];

  int passed = 0;
  int total  = 0;

  // Model state: 0 idle, 1 fill, 2 search, 3 locked
  logic [63:0] msreg;
  int          mstate, mfill, mwin, mbits;
  logic [6:0]  mpeak;
  int          seen_det, seen_to, det_bit, to_bit;

  task automatic send_bit(input logic b);
    exp_t       e;
    logic [4:0] pd, pt;
    logic [6:0] cv;
    int         agree;
    @(posedge clk_6M); #1;
    bit_en = 1'b1;
    rxbit  = b;
    mbits++;
    msreg  = {b, msreg[63:1]};
    agree  = $countones(~(msreg ^ regi_syncword));
    e.corr = 7'(agree);
    e.det  = 1'b0;
    e.to   = 1'b0;
    if (mstate == 1) begin
      mfill++;
      if (mfill == 64) begin
        if (agree >= int'(regi_correthreshold)) begin
          e.det = 1'b1; mpeak = 7'(agree); mstate = 3;
        end else begin
          mstate = 2;
        end
      end
    end else if (mstate == 2) begin
      if (agree >= int'(regi_correthreshold)) begin
        e.det = 1'b1; mpeak = 7'(agree); mstate = 3;
      end else begin
        if (mwin < 65535) mwin++;
        if (regi_search_window != 0 && mwin >= int'(regi_search_window)) begin
          e.to = 1'b1; mstate = 0;
        end
      end
    end
    q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_6M); #1;
      if (k == 0) bit_en = 1'b0;
      pd[k] = sync_detect_p;
      pt[k] = timeout_p;
      if (k == 1) cv = corr_value;
    end
    if (pd != 0) begin seen_det++; det_bit = mbits; end
    if (pt != 0) begin seen_to++;  to_bit  = mbits; end
    e = q.pop_front();
    total++;
    if (cv !== e.corr) $display("FAIL corr_value bit %0d: got %0d want %0d", mbits, cv, e.corr);
    else passed++;
    total++;
    if (pd !== (e.det ? 5'b00100 : 5'b00000))
      $display("FAIL sync_detect_p bit %0d: pattern %b want %b", mbits, pd, (e.det ? 5'b00100 : 5'b00000));
    else passed++;
    total++;
    if (pt !== (e.to ? 5'b00100 : 5'b00000))
      $display("FAIL timeout_p bit %0d: pattern %b want %b", mbits, pt, (e.to ? 5'b00100 : 5'b00000));
    else passed++;
    total++;
    if (searching !== (mstate == 1 || mstate == 2) || corr_peak !== mpeak)
      $display("FAIL status bit %0d: searching %b peak %0d want %b %0d", mbits,
               searching, corr_peak, (mstate == 1 || mstate == 2), mpeak);
    else passed++;
  endtask

  task automatic ctl(input logic s, input logic c);
    @(posedge clk_6M); #1;
    search_start_p  = s;
    search_cancel_p = c;
    if (c) mstate = 0;
    else if (s) begin mstate = 1; mfill = 0; mwin = 0; mbits = 0; end
    @(posedge clk_6M); #1;
    search_start_p  = 1'b0;
    search_cancel_p = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input logic [63:0] mask);
    for (int i = 0; i < 64; i++) send_bit(w[i] ^ mask[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic clear_seen();
    seen_det = 0; seen_to = 0; det_bit = -1; to_bit = -1;
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({sync_detect_p, corr_value, corr_peak, searching, timeout_p} !== 17'd0)
      $display("FAIL %s: outputs det=%b corr=%0d peak=%0d srch=%b to=%b want all 0", name,
               sync_detect_p, corr_value, corr_peak, searching, timeout_p);
    else passed++;
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    repeat (3) @(posedge clk_6M);
    #1;
    check_outputs_zero("reset");
    rstz = 1'b1;
    msreg = '0; mstate = 0; mpeak = '0; mfill = 0; mwin = 0; mbits = 0;
  endtask

  task automatic test_exact_word();
    regi_correthreshold = 6'd60;
    regi_search_window  = 16'd0;
    clear_seen();
    ctl(1'b1, 1'b0);
    send_word(SW, 64'd0);
    total++;
    if (seen_det !== 1 || det_bit !== 64 || corr_peak !== 7'd64 || corr_value !== 7'd64 || searching !== 1'b0)
      $display("FAIL exact_word: det %0d at %0d peak %0d corr %0d srch %b want 1 64 64 64 0",
               seen_det, det_bit, corr_peak, corr_value, searching);
    else passed++;
  endtask

  task automatic test_flipped();
    clear_seen();
    ctl(1'b1, 1'b0);
    send_word(SW, 64'h8000_0100_0010_0001);
    total++;
    if (seen_det !== 1 || corr_peak !== 7'd60)
      $display("FAIL flip4: det %0d peak %0d want 1 60", seen_det, corr_peak);
    else passed++;
    clear_seen();
    ctl(1'b1, 1'b0);
    send_word(SW, 64'h8000_0101_0010_0001);
    total++;
    if (seen_det !== 0 || corr_value !== 7'd59 || searching !== 1'b1)
      $display("FAIL flip5: det %0d corr %0d srch %b want 0 59 1", seen_det, corr_value, searching);
    else passed++;
  endtask

  task automatic test_timeout();
    ctl(1'b0, 1'b1);
    regi_search_window = 16'd10;
    clear_seen();
    ctl(1'b1, 1'b0);
    send_rand(74);
    total++;
    if (seen_to !== 1 || to_bit !== 74 || seen_det !== 0 || searching !== 1'b0)
      $display("FAIL timeout: count %0d at bit %0d det %0d srch %b want 1 74 0 0",
               seen_to, to_bit, seen_det, searching);
    else passed++;
    send_rand(12);
    total++;
    if (seen_to !== 1) $display("FAIL timeout_once: count %0d want 1", seen_to);
    else passed++;
    regi_search_window = 16'd0;
  endtask

  task automatic test_late_word();
    clear_seen();
    ctl(1'b1, 1'b0);
    send_rand(30);
    send_word(SW, 64'd0);
    total++;
    if (seen_det !== 1 || det_bit !== 94)
      $display("FAIL late_word: det %0d at bit %0d want 1 94", seen_det, det_bit);
    else passed++;
  endtask

  task automatic test_back_to_back();
    ctl(1'b1, 1'b0);
    send_rand(70);
    ctl(1'b1, 1'b1);
    total++;
    if (searching !== 1'b0) $display("FAIL start_cancel: searching %b want 0", searching);
    else passed++;
    ctl(1'b1, 1'b0);
    send_word(SW, 64'd0);
    clear_seen();
    ctl(1'b1, 1'b0);
    total++;
    if (searching !== 1'b1) $display("FAIL rearm: searching %b want 1", searching);
    else passed++;
    send_word(SW, 64'd0);
    total++;
    if (seen_det !== 1 || det_bit !== 64)
      $display("FAIL redetect: det %0d at bit %0d want 1 64", seen_det, det_bit);
    else passed++;
  endtask

  task automatic test_thresh_zero();
    regi_correthreshold = 6'd0;
    clear_seen();
    ctl(1'b1, 1'b0);
    send_rand(64);
    total++;
    if (seen_det !== 1 || det_bit !== 64)
      $display("FAIL thresh_zero: det %0d at bit %0d want 1 64", seen_det, det_bit);
    else passed++;
    regi_correthreshold = 6'd60;
  endtask

  task automatic test_reset_mid();
    ctl(1'b1, 1'b0);
    send_rand(50);
    @(posedge clk_6M); #1;
    rstz = 1'b0;
    @(posedge clk_6M); #1;
    check_outputs_zero("reset_mid");
    rstz = 1'b1;
    msreg = '0; mstate = 0; mpeak = '0; mfill = 0; mwin = 0;
    clear_seen();
    send_word(SW, 64'd0);
    total++;
    if (seen_det !== 0 || searching !== 1'b0)
      $display("FAIL no_rearm: det %0d srch %b want 0 0", seen_det, searching);
    else passed++;
  endtask

  initial begin
    rstz = 1'b0; bit_en = 1'b0; rxbit = 1'b0;
    search_start_p = 1'b0; search_cancel_p = 1'b0;
    regi_syncword = SW; regi_correthreshold = 6'd60; regi_search_window = 16'd0;
    clear_seen();
    test_reset();
    test_exact_word();
    test_flipped();
    test_timeout();
    test_late_word();
    test_back_to_back();
    test_thresh_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
